macro_select_seq: RTL and testbench

//  Drives the 4-bit `configuration` bus read by the top/side pad-line muxes.

---
 rtl/macro_select_seq_pkg.sv | 17 +
 rtl/macro_select_seq_phase_counter.sv | 41 ++++
 rtl/macro_select_seq.sv | 157 +++++++++++++++
 tb/tb_macro_select_seq.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/macro_select_seq_pkg.sv
// Shared definitions for the macro select sequencer and the pad-line muxes.
//   sel_state_e    : sequencer phase encoding
//   MACRO_CFG_W    : width of the configuration select bus
//   MACRO_NUM      : number of selectable macros (legal selects 0..MACRO_NUM-1)
package macro_sel_pkg;

  localparam int unsigned MACRO_CFG_W = 4;
  localparam int unsigned MACRO_NUM   = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DRAIN  = 2'd1,
    SWITCH = 2'd2,
    SETTLE = 2'd3
  } sel_state_e;

endpackage

// File: rtl/macro_select_seq_phase_counter.sv
// Down-counter timing the DRAIN and SETTLE phases.
//   clk, rst   : clock, synchronous active-high reset (count returns to 0)
//   load       : load load_val (takes priority over dec)
//   load_val   : reload value for a new phase
//   dec        : decrement by one; ignored at zero so the count never wraps
//   zero_c     : count is zero (combinational from the count flop)
module phase_counter #(
  parameter int unsigned CNT_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic             zero_c
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // next count: load wins, then a non-wrapping decrement
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (dec && (cnt_q != '0)) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_c = (cnt_q == '0);

endmodule

// File: rtl/macro_select_seq.sv
// Glitch-free macro select sequencer for the top/side pad-line muxes.
// A new select is applied by gating all pad OEs off, draining, switching the
// select, settling, then releasing the OEs.
//   wb_clk_i, wb_rst_i  : clock, synchronous active-high reset
//   req_valid/req_ready : configuration request handshake (ready only in IDLE)
//   req_cfg             : requested macro select
//   configuration       : registered select driven to the pad-line muxes
//   busy                : switch in progress (DRAIN/SWITCH/SETTLE)
//   switch_done         : one-cycle pulse when an accepted request completes
//   err_bad_cfg         : one-cycle pulse when an out-of-range select is accepted
//   north_oe_selected   : mux OE bus in
//   north_oe_gated      : OE bus forced inactive while busy (combinational)
//   macro_i_hold        : macro input buffers hold their last value while busy
module macro_select_seq
  import macro_sel_pkg::*;
#(
  parameter int unsigned CFG_W         = MACRO_CFG_W,
  parameter int unsigned NUM_MACROS    = MACRO_NUM,
  parameter int unsigned PAD_W         = 10,
  parameter int unsigned SETTLE_CYCLES = 4,
  parameter int unsigned RESET_CFG     = 0
) (
  input  logic             wb_clk_i,
  input  logic             wb_rst_i,
  input  logic             req_valid,
  input  logic [CFG_W-1:0] req_cfg,
  output logic             req_ready,
  output logic [CFG_W-1:0] configuration,
  output logic             busy,
  output logic             switch_done,
  output logic             err_bad_cfg,
  input  logic [PAD_W-1:0] north_oe_selected,
  output logic [PAD_W-1:0] north_oe_gated,
  output logic             macro_i_hold
);

  localparam int unsigned CNT_W = (SETTLE_CYCLES < 1) ? 1 : $clog2(SETTLE_CYCLES + 1);
  localparam logic [CNT_W-1:0] PHASE_LOAD = CNT_W'(SETTLE_CYCLES - 1);

  // parameter sanity checks at elaboration
  if (SETTLE_CYCLES < 1) begin : g_bad_settle
    $error("macro_select_seq: SETTLE_CYCLES must be >= 1");
  end
  if (RESET_CFG >= NUM_MACROS) begin : g_bad_reset_cfg
    $error("macro_select_seq: RESET_CFG must be < NUM_MACROS");
  end

  sel_state_e       state_q, state_d;
  logic [CFG_W-1:0] cfg_q, cfg_d;
  logic [CFG_W-1:0] pend_q, pend_d;
  logic             busy_q, busy_d;
  logic             ready_q, ready_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic             cnt_load;
  logic             cnt_dec;
  logic             cnt_zero;
  logic             accept;
  logic             cfg_bad;

  assign accept  = req_valid && ready_q;
  assign cfg_bad = (32'(req_cfg) >= NUM_MACROS);

  phase_counter #(
    .CNT_W (CNT_W)
  ) u_phase_counter (
    .clk      (wb_clk_i),
    .rst      (wb_rst_i),
    .load     (cnt_load),
    .load_val (PHASE_LOAD),
    .dec      (cnt_dec),
    .zero_c   (cnt_zero)
  );

  // next-state and registered-output decode
  always_comb begin
    state_d  = state_q;
    cfg_d    = cfg_q;
    pend_d   = pend_q;
    done_d   = 1'b0;
    err_d    = 1'b0;
    cnt_load = 1'b0;
    cnt_dec  = 1'b0;

    case (state_q)
      IDLE: begin
        if (accept) begin
          if (cfg_bad) begin
            err_d = 1'b1;
          end else if (req_cfg == cfg_q) begin
            // already selected: complete without gating the OEs
            done_d = 1'b1;
          end else begin
            pend_d   = req_cfg;
            state_d  = DRAIN;
            cnt_load = 1'b1;
          end
        end
      end
      DRAIN: begin
        if (cnt_zero) begin
          state_d = SWITCH;
        end else begin
          cnt_dec = 1'b1;
        end
      end
      SWITCH: begin
        cfg_d    = pend_q;
        state_d  = SETTLE;
        cnt_load = 1'b1;
      end
      SETTLE: begin
        if (cnt_zero) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end else begin
          cnt_dec = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d  = (state_d != IDLE);
    ready_d = (state_d == IDLE);
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q <= IDLE;
      cfg_q   <= CFG_W'(RESET_CFG);
      pend_q  <= CFG_W'(RESET_CFG);
      busy_q  <= 1'b0;
      ready_q <= 1'b1;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cfg_q   <= cfg_d;
      pend_q  <= pend_d;
      busy_q  <= busy_d;
      ready_q <= ready_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign req_ready      = ready_q;
  assign configuration  = cfg_q;
  assign busy           = busy_q;
  assign switch_done    = done_q;
  assign err_bad_cfg    = err_q;
  assign macro_i_hold   = busy_q;
  assign north_oe_gated = north_oe_selected & {PAD_W{~busy_q}};

endmodule

// File: tb/tb_macro_select_seq.sv
// Self-checking bench for macro_select_seq: a timing-rule model checked every
// cycle, plus hand-computed literal checks on the directed scenarios.
module tb_macro_select_seq;

  localparam int CFG_W = 4;
  localparam int NUM   = 4;
  localparam int PAD_W = 10;
  localparam int S     = 4;

  logic             clk;
  logic             rst;
  logic             req_valid;
  logic [CFG_W-1:0] req_cfg;
  logic             req_ready;
  logic [CFG_W-1:0] configuration;
  logic             busy;
  logic             switch_done;
  logic             err_bad_cfg;
  logic [PAD_W-1:0] oe_sel;
  logic [PAD_W-1:0] oe_gated;
  logic             hold;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  macro_select_seq #(
    .CFG_W         (CFG_W),
    .NUM_MACROS    (NUM),
    .PAD_W         (PAD_W),
    .SETTLE_CYCLES (S),
    .RESET_CFG     (0)
  ) dut (
    .wb_clk_i          (clk),
    .wb_rst_i          (rst),
    .req_valid         (req_valid),
    .req_cfg           (req_cfg),
    .req_ready         (req_ready),
    .configuration     (configuration),
    .busy              (busy),
    .switch_done       (switch_done),
    .err_bad_cfg       (err_bad_cfg),
    .north_oe_selected (oe_sel),
    .north_oe_gated    (oe_gated),
    .macro_i_hold      (hold)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Timing-rule model: one switch in flight, described by its accept cycle.
  bit       m_seen_rst = 0;
  bit       m_active   = 0;
  int       m_start    = 0;
  int       m_done_at  = -1;
  int       m_err_at   = -1;
  logic [3:0] m_cfg    = '0;
  logic [3:0] m_new    = '0;

  function automatic bit exp_busy(int c);
    return m_active && (c >= m_start + 1) && (c <= m_start + 2*S + 1);
  endfunction

  function automatic logic [3:0] exp_cfg(int c);
    if (m_active && (c >= m_start + S + 2)) return m_new;
    return m_cfg;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_seen_rst = 1;
      m_active   = 0;
      m_cfg      = '0;
      m_done_at  = -1;
      m_err_at   = -1;
    end else if (m_seen_rst) begin
      if (req_valid && !exp_busy(cyc)) begin
        if (int'(req_cfg) >= NUM) begin
          m_err_at = cyc + 1;
        end else if (req_cfg == exp_cfg(cyc)) begin
          m_done_at = cyc + 1;
        end else begin
          m_active  = 1;
          m_start   = cyc;
          m_new     = req_cfg;
          m_done_at = cyc + 2*S + 2;
        end
      end
      if (m_active && (cyc + 1 >= m_start + 2*S + 2)) begin
        m_cfg    = m_new;
        m_active = 0;
      end
    end
    cyc = cyc + 1;
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s (cycle %0d): got %0h expected %0h", name, cyc, got, exp);
    end
  endtask

  // per-cycle comparison against the model
  always @(negedge clk) begin
    if (m_seen_rst) begin
      chk("m_busy",   32'(busy),          32'(exp_busy(cyc)));
      chk("m_hold",   32'(hold),          32'(exp_busy(cyc)));
      chk("m_ready",  32'(req_ready),     32'(!exp_busy(cyc)));
      chk("m_cfg",    32'(configuration), 32'(exp_cfg(cyc)));
      chk("m_done",   32'(switch_done),   32'(cyc == m_done_at));
      chk("m_err",    32'(err_bad_cfg),   32'(cyc == m_err_at));
      chk("m_oe",     32'(oe_gated),      32'(exp_busy(cyc) ? '0 : oe_sel));
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic goto_cyc(input int c);
    while (cyc < c) step(1);
  endtask

  int t0;

  initial begin
    rst       = 1'b1;
    req_valid = 1'b0;
    req_cfg   = '0;
    oe_sel    = 10'h3FF;
    step(2);
    rst = 1'b0;
    step(1);

    // 1: idle after reset
    chk("rst_cfg",   32'(configuration), 32'h0);
    chk("rst_busy",  32'(busy),          32'h0);
    chk("rst_ready", 32'(req_ready),     32'h1);
    chk("rst_oe",    32'(oe_gated),      32'h3FF);

    // 3: out-of-range select
    t0 = cyc; req_valid = 1'b1; req_cfg = 4'd5;
    step(1); req_valid = 1'b0;
    chk("bad_err",  32'(err_bad_cfg),   32'h1);
    chk("bad_busy", 32'(busy),          32'h0);
    chk("bad_cfg",  32'(configuration), 32'h0);
    step(1);
    chk("bad_err_pulse", 32'(err_bad_cfg), 32'h0);

    // 4: request current select
    oe_sel = 10'h2A5;
    t0 = cyc; req_valid = 1'b1; req_cfg = 4'd0;
    step(1); req_valid = 1'b0;
    chk("same_done", 32'(switch_done), 32'h1);
    chk("same_busy", 32'(busy),        32'h0);
    chk("same_oe",   32'(oe_gated),    32'h2A5);

    // 2: full switch to 2
    oe_sel = 10'h3FF;
    t0 = cyc; req_valid = 1'b1; req_cfg = 4'd2;
    step(1); req_valid = 1'b0;
    chk("sw_busy1", 32'(busy),     32'h1);
    chk("sw_oe1",   32'(oe_gated), 32'h0);
    goto_cyc(t0 + 5);
    chk("sw_cfg5",  32'(configuration), 32'h0);
    goto_cyc(t0 + 6);
    chk("sw_cfg6",  32'(configuration), 32'h2);
    goto_cyc(t0 + 9);
    chk("sw_busy9", 32'(busy),        32'h1);
    chk("sw_done9", 32'(switch_done), 32'h0);
    goto_cyc(t0 + 10);
    chk("sw_done10",  32'(switch_done), 32'h1);
    chk("sw_busy10",  32'(busy),        32'h0);
    chk("sw_ready10", 32'(req_ready),   32'h1);
    chk("sw_oe10",    32'(oe_gated),    32'h3FF);

    // 5: req_cfg changes mid-switch, valid held until ready
    oe_sel = 10'h155;
    t0 = cyc; req_valid = 1'b1; req_cfg = 4'd3;
    goto_cyc(t0 + 2); req_cfg = 4'd1;
    goto_cyc(t0 + 10);
    chk("chg_cfg10",   32'(configuration), 32'h3);
    chk("chg_ready10", 32'(req_ready),     32'h1);
    step(1); req_valid = 1'b0;
    chk("chg_accept", 32'(busy), 32'h1);
    goto_cyc(t0 + 10 + 2*S + 2);
    chk("chg_final", 32'(configuration), 32'h1);
    chk("chg_done",  32'(switch_done),   32'h1);

    // 6: reset mid-switch
    rst = 1'b1; step(1); rst = 1'b0; step(1);
    oe_sel = 10'h3FF;
    t0 = cyc; req_valid = 1'b1; req_cfg = 4'd1;
    step(1); req_valid = 1'b0;
    goto_cyc(t0 + 3); rst = 1'b1;
    goto_cyc(t0 + 4); rst = 1'b0;
    chk("rmid_busy", 32'(busy),          32'h0);
    chk("rmid_cfg",  32'(configuration), 32'h0);
    goto_cyc(t0 + 10);
    chk("rmid_done", 32'(switch_done), 32'h0);
    chk("rmid_cfg2", 32'(configuration), 32'h0);
    step(3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
